// File: rtl/multicycle_control.sv
`default_nettype none
// multicycle_control: main control FSM of the multicycle MIPS-subset CPU.
// Rev 1.0 -- initial release.
module multicycle_control #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter logic [5:0] J_OP    = 6'b111000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic [3:0] State,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       Halted
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  state_e     state_q, state_d;
  logic       run_q;

  logic       w_is_alu, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_halt, w_is_undef;
  logic [2:0] w_aluop;
  logic       w_regdst, w_srca, w_srcb, w_ext;
  logic       w_pcwre, w_irwre, w_regwre, w_memwrite;
  logic [1:0] w_pcsrc;

  // run_q holds off the first fetch strobe until one clock edge has seen RST released.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    w_is_alu = 1'b0;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    w_is_beq = 1'b0;
    w_aluop  = 3'b000;
    w_regdst = 1'b0;
    w_srca   = 1'b0;
    w_srcb   = 1'b0;
    w_ext    = 1'b1;
    case (Opcode)
      OP_ADD:  begin w_is_alu = 1'b1; w_regdst = 1'b1; end
      OP_SUB:  begin w_is_alu = 1'b1; w_regdst = 1'b1; w_aluop = 3'b001; end
      OP_ADDI: begin w_is_alu = 1'b1; w_srcb = 1'b1; end
      OP_OR:   begin w_is_alu = 1'b1; w_regdst = 1'b1; w_aluop = 3'b101; end
      OP_AND:  begin w_is_alu = 1'b1; w_regdst = 1'b1; w_aluop = 3'b110; end
      OP_ORI:  begin w_is_alu = 1'b1; w_srcb = 1'b1; w_aluop = 3'b101; w_ext = 1'b0; end
      OP_SLL:  begin w_is_alu = 1'b1; w_regdst = 1'b1; w_srca = 1'b1; w_aluop = 3'b100; end
      OP_SLT:  begin w_is_alu = 1'b1; w_regdst = 1'b1; w_aluop = 3'b010; end
      OP_SW:   begin w_is_sw = 1'b1; w_srcb = 1'b1; end
      OP_LW:   begin w_is_lw = 1'b1; w_srcb = 1'b1; end
      OP_BEQ:  begin w_is_beq = 1'b1; w_aluop = 3'b001; end
      default: ;
    endcase
    w_is_j     = (Opcode == J_OP);
    w_is_halt  = (Opcode == HALT_OP) && !w_is_j;
    w_is_undef = !(w_is_alu || w_is_lw || w_is_sw || w_is_beq || w_is_j || w_is_halt);
  end

  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = S_IF;
    end else begin
      case (state_q)
        S_IF:     state_d = S_ID;
        S_ID: begin
          if (w_is_j)                  state_d = S_IF;
          else if (w_is_halt)          state_d = S_HALT;
          else if (w_is_beq)           state_d = S_EXE_BR;
          else if (w_is_lw || w_is_sw) state_d = S_EXE_LS;
          else if (w_is_alu)           state_d = S_EXE_AL;
          else                         state_d = S_IF;
        end
        S_EXE_LS: state_d = S_MEM;
        S_MEM:    state_d = w_is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  state_d = S_IF;
        S_EXE_BR: state_d = S_IF;
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL:  state_d = S_IF;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_IF;
      endcase
    end
  end

  always_comb begin
    w_pcwre    = 1'b0;
    w_irwre    = 1'b0;
    w_regwre   = 1'b0;
    w_memwrite = 1'b0;
    w_pcsrc    = 2'b00;
    case (state_q)
      S_IF: w_irwre = 1'b1;
      S_ID: begin
        if (w_is_j) begin
          w_pcwre = 1'b1;
          w_pcsrc = 2'b10;
        end else if (w_is_undef) begin
          w_pcwre = 1'b1;
        end
      end
      S_EXE_BR: begin
        w_pcwre = 1'b1;
        if (Zero) w_pcsrc = 2'b01;
      end
      S_MEM: begin
        if (w_is_sw) begin
          w_pcwre    = 1'b1;
          w_memwrite = 1'b1;
        end
      end
      S_WB_LD, S_WB_AL: begin
        w_pcwre  = 1'b1;
        w_regwre = 1'b1;
      end
      default: ;
    endcase
  end

  assign State    = state_q;
  assign Halted   = (state_q == S_HALT);
  assign PCWre    = w_pcwre & run_q;
  assign IRWre    = w_irwre & run_q;
  assign RegWre   = w_regwre & run_q;
  assign MemWrite = w_memwrite & run_q;
  assign MemToReg = (state_q == S_WB_LD);
  assign PCSrc    = run_q ? w_pcsrc : 2'b00;
  assign ALUOp    = RST ? w_aluop : 3'b000;
  assign RegDst   = w_regdst;
  assign ALUSrcA  = w_srca;
  assign ALUSrcB  = w_srcb;
  assign ExtSel   = w_ext;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control: self-checking bench for the multicycle control FSM.
// Rev 1.0 -- initial release.
module tb_multicycle_control;

  localparam logic [5:0] OPC_ADD  = 6'b000000;
  localparam logic [5:0] OPC_SUB  = 6'b000001;
  localparam logic [5:0] OPC_ADDI = 6'b000010;
  localparam logic [5:0] OPC_OR   = 6'b010000;
  localparam logic [5:0] OPC_AND  = 6'b010001;
  localparam logic [5:0] OPC_ORI  = 6'b010010;
  localparam logic [5:0] OPC_SLL  = 6'b011000;
  localparam logic [5:0] OPC_SLT  = 6'b100110;
  localparam logic [5:0] OPC_SW   = 6'b110000;
  localparam logic [5:0] OPC_LW   = 6'b110001;
  localparam logic [5:0] OPC_BEQ  = 6'b110100;
  localparam logic [5:0] OPC_J    = 6'b111000;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam int C_NOP = 0, C_J = 1, C_HALT = 2, C_BEQ = 3, C_LW = 4, C_SW = 5, C_ALU = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = '0;
  logic       Zero = 1'b0;
  logic [3:0] State;
  logic       PCWre, IRWre, RegWre, MemWrite, MemToReg, RegDst, ALUSrcA, ALUSrcB, ExtSel, Halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;

  int checks = 0;
  int errors = 0;

  logic [11:0] act_w;
  logic [6:0]  sel_w;
  assign act_w = {State, PCWre, IRWre, RegWre, MemWrite, MemToReg, PCSrc, Halted};
  assign sel_w = {ALUOp, RegDst, ALUSrcA, ALUSrcB, ExtSel};

  multicycle_control dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .State(State),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         lat;
    logic [6:0] sel;   // {ALUOp, RegDst, ALUSrcA, ALUSrcB, ExtSel}
  } vec_t;

  function automatic int ref_class(input logic [5:0] op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_ADDI, OPC_OR, OPC_AND, OPC_ORI, OPC_SLL, OPC_SLT: return C_ALU;
      OPC_SW:   return C_SW;
      OPC_LW:   return C_LW;
      OPC_BEQ:  return C_BEQ;
      OPC_J:    return C_J;
      OPC_HALT: return C_HALT;
      default:  return C_NOP;
    endcase
  endfunction

  function automatic logic [6:0] ref_sel(input logic [5:0] op);
    case (op)
      OPC_ADD:  return 7'b000_1_0_0_1;
      OPC_SUB:  return 7'b001_1_0_0_1;
      OPC_ADDI: return 7'b000_0_0_1_1;
      OPC_OR:   return 7'b101_1_0_0_1;
      OPC_AND:  return 7'b110_1_0_0_1;
      OPC_ORI:  return 7'b101_0_0_1_0;
      OPC_SLL:  return 7'b100_1_1_0_1;
      OPC_SLT:  return 7'b010_1_0_0_1;
      OPC_SW:   return 7'b000_0_0_1_1;
      OPC_LW:   return 7'b000_0_0_1_1;
      OPC_BEQ:  return 7'b001_0_0_0_1;
      default:  return 7'b000_0_0_0_1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_out(input string tag);
    chk({tag, "_state"}, {28'd0, State}, 32'd0);
    chk({tag, "_strobes"}, {28'd0, PCWre, IRWre, RegWre, MemWrite}, 32'd0);
    chk({tag, "_halted_pcsrc_aluop"}, {26'd0, Halted, PCSrc, ALUOp}, 32'd0);
  endtask

  // Entered with RST low; returns at posedge+2 of the first cycle that may fetch.
  task automatic release_reset(input string tag);
    @(posedge CLK); #2;
    chk_reset_out({tag, "_hold"});
    RST = 1'b1;
    #2;
    chk({tag, "_prerun"}, {27'd0, State, IRWre}, 32'd0);
    @(posedge CLK); #2;
  endtask

  // Every instruction fetches in its first cycle and updates the PC in its last;
  // register/memory writes and PC source all belong to that last cycle.
  task automatic run_instr(input logic [5:0] op, input logic zero,
                           output int lat, output logic [6:0] sel_id);
    int          cls;
    int          trace[$];
    logic [11:0] exp;
    logic [1:0]  pcsrc;
    logic        last;
    cls = ref_class(op);
    trace.push_back(0);
    trace.push_back(1);
    case (cls)
      C_BEQ: trace.push_back(5);
      C_LW:  begin trace.push_back(2); trace.push_back(3); trace.push_back(4); end
      C_SW:  begin trace.push_back(2); trace.push_back(3); end
      C_ALU: begin trace.push_back(6); trace.push_back(7); end
      default: ;
    endcase
    sel_id = '0;
    for (int k = 0; k < trace.size(); k++) begin
      last  = (k == trace.size() - 1);
      Opcode = op;
      Zero   = (trace[k] == 5) ? zero : 1'($urandom);
      #2;
      pcsrc = 2'b00;
      if (last && cls == C_J) pcsrc = 2'b10;
      else if (last && cls == C_BEQ && zero) pcsrc = 2'b01;
      exp = {4'(trace[k]), last, (k == 0), last && (cls == C_LW || cls == C_ALU),
             last && (cls == C_SW), last && (cls == C_LW), pcsrc, 1'b0};
      chk($sformatf("op%b_z%0d_step%0d", op, zero, k), {20'd0, act_w}, {20'd0, exp});
      chk($sformatf("op%b_sel_step%0d", op, k), {25'd0, sel_w}, {25'd0, ref_sel(op)});
      if (k == 1) sel_id = sel_w;
      @(posedge CLK); #2;
    end
    chk($sformatf("op%b_next_if", op), {28'd0, State}, 32'd0);
    lat = (State == 4'd0) ? trace.size() : -1;
  endtask

  vec_t       tbl[14];
  logic [5:0] defined_ops[12];

  initial begin
    int         lat;
    logic [6:0] sel_id;
    logic [5:0] op;
    logic [11:0] exp;

    tbl[0]  = '{OPC_ADD,  1'b0, 4, 7'b000_1_0_0_1};
    tbl[1]  = '{OPC_SUB,  1'b0, 4, 7'b001_1_0_0_1};
    tbl[2]  = '{OPC_ADDI, 1'b0, 4, 7'b000_0_0_1_1};
    tbl[3]  = '{OPC_OR,   1'b0, 4, 7'b101_1_0_0_1};
    tbl[4]  = '{OPC_AND,  1'b0, 4, 7'b110_1_0_0_1};
    tbl[5]  = '{OPC_ORI,  1'b0, 4, 7'b101_0_0_1_0};
    tbl[6]  = '{OPC_SLL,  1'b0, 4, 7'b100_1_1_0_1};
    tbl[7]  = '{OPC_SLT,  1'b0, 4, 7'b010_1_0_0_1};
    tbl[8]  = '{OPC_LW,   1'b0, 5, 7'b000_0_0_1_1};
    tbl[9]  = '{OPC_SW,   1'b0, 4, 7'b000_0_0_1_1};
    tbl[10] = '{OPC_BEQ,  1'b1, 3, 7'b001_0_0_0_1};
    tbl[11] = '{OPC_BEQ,  1'b0, 3, 7'b001_0_0_0_1};
    tbl[12] = '{OPC_J,    1'b0, 2, 7'b000_0_0_0_1};
    tbl[13] = '{6'b101010, 1'b0, 2, 7'b000_0_0_0_1};
    defined_ops = '{OPC_ADD, OPC_SUB, OPC_ADDI, OPC_OR, OPC_AND, OPC_ORI,
                    OPC_SLL, OPC_SLT, OPC_SW, OPC_LW, OPC_BEQ, OPC_J};

    // Power-up reset with an opcode whose ALUOp is non-zero.
    Opcode = OPC_SLL;
    Zero   = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk_reset_out("rst_init");
    release_reset("rst_init");

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].zero, lat, sel_id);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_sel", i), {25'd0, sel_id}, {25'd0, tbl[i].sel});
    end

    // Reset asserted in the middle of a load's EXE_LS cycle.
    Opcode = OPC_LW;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("mid_lw_in_exe_ls", {28'd0, State}, 32'd2);
    #1 RST = 1'b0;
    #1;
    chk_reset_out("rst_mid");
    release_reset("rst_mid");
    run_instr(OPC_LW, 1'b0, lat, sel_id);
    chk("after_mid_rst_lw_latency", lat, 5);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 12) == 12) begin
        op = 6'b101010;
        for (int t = 0; t < 50; t++) begin
          op = 6'($urandom);
          if (ref_class(op) == C_NOP) break;
        end
        if (ref_class(op) != C_NOP) op = 6'b101010;
      end else begin
        op = defined_ops[$urandom_range(0, 11)];
      end
      run_instr(op, 1'($urandom), lat, sel_id);
    end

    // HALT: fetch, decode without PC update, then parked with opcode/Zero ignored.
    for (int k = 0; k < 12; k++) begin
      Opcode = (k < 2) ? OPC_HALT : 6'($urandom);
      Zero   = 1'($urandom);
      #2;
      if (k == 0)      exp = {4'd0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0};
      else if (k == 1) exp = {4'd1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
      else             exp = {4'd8, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1};
      chk($sformatf("halt_step%0d", k), {20'd0, act_w}, {20'd0, exp});
      @(posedge CLK); #2;
    end
    RST = 1'b0;
    #1;
    chk_reset_out("rst_halt");
    release_reset("rst_halt");
    run_instr(OPC_ADD, 1'b0, lat, sel_id);
    chk("after_halt_add_latency", lat, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
